// File: rtl/msr_irq_ctrl.sv
// Machine state register (EE/ME/LE) with prioritised external interrupt request, SRR0/SRR1 save and rfi restore.
// Define MSR_IRQ_EDGE_EN for edge-triggered interrupt lines; otherwise lines are level-sampled every cycle.
module msr_irq_ctrl #(
    parameter int                  NUM_IRQ    = 4,
    parameter int                  PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] VEC_BASE   = 32'h0000_0500,
    parameter logic [PC_WIDTH-1:0] VEC_STRIDE = 32'h0000_0020
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr,
    input  logic [0:31]         wd,
    output logic [0:31]         rd,
    output logic                EE,
    output logic                ME,
    output logic                LE,
    input  logic [NUM_IRQ-1:0]  irq,
    output logic                int_req,
    output logic [3:0]          int_id,
    output logic [PC_WIDTH-1:0] int_vec,
    input  logic                int_ack,
    input  logic [PC_WIDTH-1:0] int_pc,
    input  logic                rfi,
    input  logic                spr_wr,
    input  logic                spr_sel,
    input  logic [31:0]         spr_wd,
    output logic [PC_WIDTH-1:0] srr0,
    output logic [0:31]         srr1
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t              state_reg, state_next;
    logic [3:0]          id_reg, id_next, first_id;
    logic                ee_reg, me_reg, le_reg;
    logic                srr1_ee_reg, srr1_me_reg, srr1_le_reg;
    logic [PC_WIDTH-1:0] srr0_reg;
    logic [NUM_IRQ-1:0]  pending_reg;
    logic                ack_take;
    logic                unused_bits;

    assign ack_take    = (state_reg == REQ) && int_ack;
    assign unused_bits = ^{wd[0:15], wd[17:18], wd[20:30], spr_wd};

    // Lowest set index wins, so scan from the top down.
    always_comb begin
        first_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending_reg[i]) first_id = 4'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            id_reg    <= '0;
        end else begin
            state_reg <= state_next;
            id_reg    <= id_next;
        end
    end

    // Once raised, the request stays up until acknowledged.
    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        case (state_reg)
            IDLE: begin
                if (ee_reg && (|pending_reg)) begin
                    state_next = REQ;
                    id_next    = first_id;
                end
            end
            REQ: begin
                if (int_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ee_reg <= 1'b0;
            me_reg <= 1'b0;
            le_reg <= 1'b0;
        end else if (ack_take) begin
            ee_reg <= 1'b0;
        end else if (rfi) begin
            ee_reg <= srr1_ee_reg;
            me_reg <= srr1_me_reg;
            le_reg <= srr1_le_reg;
        end else if (wr) begin
            ee_reg <= wd[16];
            me_reg <= wd[19];
            le_reg <= wd[31];
        end
    end

    // spr_wd is LSB-0, so MSR positions 16/19/31 land on bits 15/12/0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            srr0_reg    <= '0;
            srr1_ee_reg <= 1'b0;
            srr1_me_reg <= 1'b0;
            srr1_le_reg <= 1'b0;
        end else if (ack_take) begin
            srr0_reg    <= int_pc;
            srr1_ee_reg <= ee_reg;
            srr1_me_reg <= me_reg;
            srr1_le_reg <= le_reg;
        end else if (spr_wr) begin
            if (spr_sel) begin
                srr1_ee_reg <= spr_wd[15];
                srr1_me_reg <= spr_wd[12];
                srr1_le_reg <= spr_wd[0];
            end else begin
                srr0_reg <= PC_WIDTH'(spr_wd);
            end
        end
    end

`ifdef MSR_IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] irq_d_reg;
`endif

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_pend
`ifdef MSR_IRQ_EDGE_EN
            // A new rising edge takes precedence over the service clear.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    irq_d_reg[gi]   <= 1'b0;
                    pending_reg[gi] <= 1'b0;
                end else begin
                    irq_d_reg[gi] <= irq[gi];
                    if (irq[gi] && !irq_d_reg[gi]) begin
                        pending_reg[gi] <= 1'b1;
                    end else if (ack_take && (id_reg == 4'(gi))) begin
                        pending_reg[gi] <= 1'b0;
                    end
                end
            end
`else
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    pending_reg[gi] <= 1'b0;
                end else begin
                    pending_reg[gi] <= irq[gi];
                end
            end
`endif
        end
    endgenerate

    always_comb begin
        rd       = '0;
        rd[16]   = ee_reg;
        rd[19]   = me_reg;
        rd[31]   = le_reg;
        srr1     = '0;
        srr1[16] = srr1_ee_reg;
        srr1[19] = srr1_me_reg;
        srr1[31] = srr1_le_reg;
    end

    assign EE      = ee_reg;
    assign ME      = me_reg;
    assign LE      = le_reg;
    assign srr0    = srr0_reg;
    assign int_req = (state_reg == REQ);
    assign int_id  = id_reg;
    assign int_vec = VEC_BASE + PC_WIDTH'(id_reg) * VEC_STRIDE;

endmodule

// File: tb/tb_msr_irq_ctrl.sv
// Self-checking bench for msr_irq_ctrl: directed table, corner sequences, then random stimulus against a word-level model.
module tb_msr_irq_ctrl;
    localparam int NUM_IRQ = 4;
    localparam int PC_WIDTH = 32;
    localparam logic [31:0] VBASE = 32'h0000_0500;
    localparam logic [31:0] VSTRIDE = 32'h0000_0020;

    logic clk = 1'b0;
    logic rst_n, wr, int_ack, rfi, spr_wr, spr_sel;
    logic [0:31] wd, rd, srr1;
    logic EE, ME, LE, int_req;
    logic [NUM_IRQ-1:0] irq;
    logic [3:0] int_id;
    logic [31:0] int_vec, int_pc, spr_wd, srr0;

    always #5 clk = ~clk;

    msr_irq_ctrl #(.NUM_IRQ(NUM_IRQ), .PC_WIDTH(PC_WIDTH), .VEC_BASE(VBASE), .VEC_STRIDE(VSTRIDE)) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .wd(wd), .rd(rd), .EE(EE), .ME(ME), .LE(LE),
        .irq(irq), .int_req(int_req), .int_id(int_id), .int_vec(int_vec), .int_ack(int_ack),
        .int_pc(int_pc), .rfi(rfi), .spr_wr(spr_wr), .spr_sel(spr_sel), .spr_wd(spr_wd),
        .srr0(srr0), .srr1(srr1)
    );

    typedef struct {
        bit          rst_n, wr, ack, rfi, spr_wr, spr_sel;
        logic [31:0] wd, pc, spr_wd;
        logic [3:0]  irq;
    } in_t;

    typedef struct {
        in_t         in;
        bit          req;
        int          id;
        logic [31:0] rd, srr0, srr1;
    } vec_t;

    int n_checks = 0;
    int n_err = 0;

    // Reference model: MSR and SRR1 kept as plain 32-bit words (value weights 0x8000/0x1000/0x0001).
    logic [31:0] m_msr, m_srr0, m_srr1;
    bit   [15:0] m_pend, m_irq_d;
    bit          m_req;
    int          m_id;

    function automatic logic [31:0] msr_mask(input logic [31:0] w);
        return w & 32'h0000_9001;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input in_t s);
        logic [31:0] msr_old;
        bit   [15:0] pend_old;
        bit          ack_t;
        msr_old  = m_msr;
        pend_old = m_pend;
        ack_t    = m_req && s.ack;
        if (!s.rst_n) begin
            m_msr = 0; m_srr0 = 0; m_srr1 = 0; m_pend = 0; m_irq_d = 0; m_req = 0; m_id = 0;
            return;
        end
        if (ack_t) m_msr = msr_old & ~32'h0000_8000;
        else if (rfi_of(s)) m_msr = m_srr1;
        else if (s.wr) m_msr = msr_mask(s.wd);
        if (ack_t) begin
            m_srr0 = s.pc;
            m_srr1 = msr_old;
        end else if (s.spr_wr) begin
            if (s.spr_sel) m_srr1 = msr_mask(s.spr_wd);
            else m_srr0 = s.spr_wd;
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
`ifdef MSR_IRQ_EDGE_EN
            if (s.irq[i] && !m_irq_d[i]) m_pend[i] = 1'b1;
            else if (ack_t && m_id == i) m_pend[i] = 1'b0;
            m_irq_d[i] = s.irq[i];
`else
            m_pend[i] = s.irq[i];
`endif
        end
        if (m_req) begin
            if (s.ack) m_req = 0;
        end else if (msr_old[15] && pend_old != 0) begin
            m_req = 1;
            for (int i = NUM_IRQ - 1; i >= 0; i--) if (pend_old[i]) m_id = i;
        end
    endtask

    function automatic bit rfi_of(input in_t s);
        return s.rfi;
    endfunction

    task automatic check_model();
        logic [31:0] rd_w, srr1_w, vec_exp;
        rd_w    = rd;
        srr1_w  = srr1;
        vec_exp = VBASE + 32'(m_id) * VSTRIDE;
        chk("m_req", int_req, m_req);
        chk("m_id", int_id, m_id);
        chk("m_vec", int_vec, vec_exp);
        chk("m_rd", rd_w, m_msr);
        chk("m_ee", {ME, EE, LE}, {m_msr[12], m_msr[15], m_msr[0]});
        chk("m_srr0", srr0, m_srr0);
        chk("m_srr1", srr1_w, m_srr1);
    endtask

    task automatic cycle(input in_t s);
        rst_n = s.rst_n; wr = s.wr; wd = s.wd; irq = s.irq; int_ack = s.ack; int_pc = s.pc;
        rfi = s.rfi; spr_wr = s.spr_wr; spr_sel = s.spr_sel; spr_wd = s.spr_wd;
        @(posedge clk);
        model_step(s);
        @(negedge clk);
        check_model();
        $display("cyc rst_n=%0b wr=%0b irq=%b ack=%0b rfi=%0b -> req=%0b id=%0d rd=%h srr0=%h",
                 s.rst_n, s.wr, s.irq, s.ack, s.rfi, int_req, int_id, rd, srr0);
    endtask

    function automatic in_t idle();
        in_t s;
        s = '{rst_n: 1'b1, wr: 1'b0, ack: 1'b0, rfi: 1'b0, spr_wr: 1'b0, spr_sel: 1'b0,
              wd: 32'h0, pc: 32'h0, spr_wd: 32'h0, irq: 4'h0};
        return s;
    endfunction

    function automatic vec_t row(input bit rn, input bit w, input logic [31:0] d, input logic [3:0] q,
                                 input bit a, input logic [31:0] pc, input bit r, input bit req,
                                 input int id, input logic [31:0] erd, input logic [31:0] es0,
                                 input logic [31:0] es1);
        vec_t v;
        v.in = idle();
        v.in.rst_n = rn; v.in.wr = w; v.in.wd = d; v.in.irq = q; v.in.ack = a; v.in.pc = pc; v.in.rfi = r;
        v.req = req; v.id = id; v.rd = erd; v.srr0 = es0; v.srr1 = es1;
        return v;
    endfunction

    vec_t tbl[8];
    in_t  s;
    logic [31:0] w;

`ifdef MSR_IRQ_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    initial begin
        // 0x8801 sets EE and LE; bit 0x0800 is not an MSR position and reads back 0.
        tbl[0] = row(0, 0, 32'h0,      4'h0, 0, 32'h0,    0, 0, 0, 32'h0,    32'h0,    32'h0);
        tbl[1] = row(1, 1, 32'h8801,   4'h0, 0, 32'h0,    0, 0, 0, 32'h8001, 32'h0,    32'h0);
        tbl[2] = row(0, 0, 32'h0,      4'h0, 0, 32'h0,    0, 0, 0, 32'h0,    32'h0,    32'h0);
        tbl[3] = row(1, 1, 32'h9001,   4'h0, 0, 32'h0,    0, 0, 0, 32'h9001, 32'h0,    32'h0);
        tbl[4] = row(1, 0, 32'h0,      4'h6, 0, 32'h0,    0, 0, 0, 32'h9001, 32'h0,    32'h0);
        tbl[5] = row(1, 0, 32'h0,      4'h6, 0, 32'h0,    0, 1, 1, 32'h9001, 32'h0,    32'h0);
        tbl[6] = row(1, 0, 32'h0,      4'h0, 1, 32'h1000, 0, 0, 1, 32'h1001, 32'h1000, 32'h9001);
        tbl[7] = row(1, 0, 32'h0,      4'h0, 0, 32'h0,    1, 0, 1, 32'h9001, 32'h1000, 32'h9001);

        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].in);
            w = rd;
            chk($sformatf("tbl%0d_rd", i), w, tbl[i].rd);
            chk($sformatf("tbl%0d_req", i), int_req, tbl[i].req);
            chk($sformatf("tbl%0d_id", i), int_id, tbl[i].id);
            chk($sformatf("tbl%0d_srr0", i), srr0, tbl[i].srr0);
            w = srr1;
            chk($sformatf("tbl%0d_srr1", i), w, tbl[i].srr1);
        end
        chk("tbl5_vec_hint", int_vec, 32'h520 - 32'h20 * 1 + 32'h20); // id still 1 after ack

        // Edge mode: line 2 is still pending after rfi.
        cycle(idle());
        chk("after_rfi_req", int_req, EDGE);
        s = idle(); s.irq = 4'h4;
        cycle(s); cycle(s);
        chk("line2_req", int_req, 1'b1);
        chk("line2_id", int_id, 4'd2);
        chk("line2_vec", int_vec, 32'h540);
        // ack beats both wr and spr_wr in the same cycle
        s = idle(); s.ack = 1; s.pc = 32'h2000; s.wr = 1; s.wd = 32'h0;
        s.spr_wr = 1; s.spr_sel = 0; s.spr_wd = 32'hDEAD;
        cycle(s);
        chk("ackwin_srr0", srr0, 32'h2000);
        w = rd;   chk("ackwin_rd", w, 32'h1001);
        w = srr1; chk("ackwin_srr1", w, 32'h9001);
        chk("ackwin_req", int_req, 1'b0);

        // EE=0 masks the request until wr raises EE.
        s = idle(); s.rst_n = 0; cycle(s);
        s = idle(); s.wr = 1; s.wd = 32'h0001; cycle(s);
        s = idle(); s.irq = 4'h1;
        for (int i = 0; i < 3; i++) begin
            cycle(s);
            chk("masked_req", int_req, 1'b0);
        end
        s.wr = 1; s.wd = 32'h8001; cycle(s);
        chk("ee_rise_req", int_req, 1'b0);
        s.wr = 0; cycle(s);
        chk("ee_req", int_req, 1'b1);
        chk("ee_vec", int_vec, 32'h500);
        s.ack = 1; s.pc = 32'h3000; cycle(s);
        w = srr1; chk("ack2_srr1", w, 32'h8001);
        s.ack = 0; s.rfi = 1; cycle(s);
        w = rd; chk("rfi2_rd", w, 32'h8001);
        s.rfi = 0;
        // Held line: edge mode gives no second request, level mode re-requests.
        for (int i = 0; i < 3; i++) begin
            cycle(s);
            chk("held_req", int_req, !EDGE);
        end
        s.irq = 4'h0; cycle(s);
        s.irq = 4'h1; cycle(s); cycle(s);
        chk("pulse_req", int_req, 1'b1);
        chk("pulse_id", int_id, 4'd0);
        s.rst_n = 0; cycle(s);
        chk("midrst_req", int_req, 1'b0);
        w = rd; chk("midrst_rd", w, 32'h0);
        chk("midrst_vec", int_vec, 32'h500);

        // Random phase against the model.
        s = idle();
        for (int n = 0; n < 3000; n++) begin
            s.rst_n   = ($urandom_range(0, 99) != 0);
            s.wr      = ($urandom_range(0, 9) == 0);
            s.wd      = $urandom;
            if ($urandom_range(0, 3) == 0) s.irq = 4'($urandom);
            s.ack     = m_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            s.pc      = $urandom;
            s.rfi     = ($urandom_range(0, 11) == 0);
            s.spr_wr  = ($urandom_range(0, 9) == 0);
            s.spr_sel = 1'($urandom);
            s.spr_wd  = $urandom;
            cycle(s);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
